// File: rtl/sacc_lane_accumulator.sv
// Lane-wise signed accumulator for packed multiplier products (8xINT8 / 4xINT16 / 2xINT32 / 1xINT64).
// Define ACC_SATURATE_EN to clamp overflowing lanes; otherwise lanes wrap and only flag overflow.
//
// state | meaning
// IDLE  | no result in progress, waiting for the first product
// ACCUM | summing products until count reaches the latched length
// HOLD  | result presented on acc_data until the downstream handshake
module sacc_lane_accumulator #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclr,
    input  logic             prod_valid,
    input  logic [63:0]      prod_data,
    output logic             prod_ready,
    input  logic [3:0]       select_precision,
    input  logic [LEN_W-1:0] acc_len,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [63:0]      acc_data,
    output logic [7:0]       acc_overflow,
    output logic             prec_err
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state, state_next;
    logic [2:0]       lane_mask_q, lane_mask_in;
    logic [LEN_W:0]   len_q, len_in, count_q, count_inc;
    logic [63:0]      acc_q, sum;
    logic [7:0]       ovf_q, sum_ovf, lane_ovf;
    logic [8:0]       byte_sum;
    logic             carry, prec_bad, prec_err_q;
    logic             accept, load, add;

    // lane_mask = bytes per lane - 1; anything not one-hot runs as INT64
    always_comb begin
        lane_mask_in = 3'd7;
        prec_bad     = 1'b0;
        case (select_precision)
            4'b0001: lane_mask_in = 3'd0;
            4'b0010: lane_mask_in = 3'd1;
            4'b0100: lane_mask_in = 3'd3;
            4'b1000: lane_mask_in = 3'd7;
            default: prec_bad     = 1'b1;
        endcase
    end

    assign len_in    = {(acc_len == '0), acc_len};
    assign count_inc = count_q + 1'b1;

    // byte-sliced adder: carry is cut at each lane start, overflow judged at each lane's top byte
    always_comb begin
        sum      = '0;
        sum_ovf  = '0;
        lane_ovf = '0;
        carry    = 1'b0;
        byte_sum = '0;
        for (int j = 0; j < 8; j++) begin
            if ((3'(j) & lane_mask_q) == 3'd0)
                carry = 1'b0;
            byte_sum = {1'b0, acc_q[8*j +: 8]} + {1'b0, prod_data[8*j +: 8]} + {8'd0, carry};
            sum[8*j +: 8] = byte_sum[7:0];
            carry = byte_sum[8];
            if ((3'(j) & lane_mask_q) == lane_mask_q)
                lane_ovf[j] = (acc_q[8*j+7] == prod_data[8*j+7]) && (byte_sum[7] != acc_q[8*j+7]);
        end
        for (int j = 0; j < 8; j++)
            sum_ovf[j] = lane_ovf[3'(j) | lane_mask_q];
`ifdef ACC_SATURATE_EN
        for (int j = 0; j < 8; j++) begin
            if (sum_ovf[j]) begin
                if ((3'(j) | lane_mask_q) == 3'(j))
                    sum[8*j +: 8] = acc_q[8*(3'(j) | lane_mask_q) + 7] ? 8'h80 : 8'h7F;
                else
                    sum[8*j +: 8] = acc_q[8*(3'(j) | lane_mask_q) + 7] ? 8'h00 : 8'hFF;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (sclr)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        add        = 1'b0;
        prod_ready = (state != HOLD) || acc_ready;
        acc_valid  = (state == HOLD);
        accept     = prod_valid && prod_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    load       = 1'b1;
                    state_next = (len_in == 1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    add = 1'b1;
                    if (count_inc == len_q)
                        state_next = HOLD;
                end
            end
            HOLD: begin
                if (acc_ready) begin
                    if (accept) begin
                        load       = 1'b1;
                        state_next = (len_in == 1) ? HOLD : ACCUM;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_mask_q <= '0;
            len_q       <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            ovf_q       <= '0;
            prec_err_q  <= 1'b0;
        end else if (sclr) begin
            lane_mask_q <= '0;
            len_q       <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            ovf_q       <= '0;
            prec_err_q  <= 1'b0;
        end else if (load) begin
            lane_mask_q <= lane_mask_in;
            len_q       <= len_in;
            count_q     <= 1;
            acc_q       <= prod_data;
            ovf_q       <= '0;
            if (prec_bad)
                prec_err_q <= 1'b1;
        end else if (add) begin
            count_q <= count_inc;
            acc_q   <= sum;
            ovf_q   <= ovf_q | sum_ovf;
        end
    end

    assign acc_data     = acc_q;
    assign acc_overflow = ovf_q;
    assign prec_err     = prec_err_q;

endmodule

// File: tb/tb_sacc_lane_accumulator.sv
// Self-checking bench for sacc_lane_accumulator: directed corner cases plus randomized results
// checked against a per-lane arithmetic model (honours ACC_SATURATE_EN when defined).
module tb_sacc_lane_accumulator;
    localparam int LEN_W = 8;
`ifdef ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, sclr, prod_valid, prod_ready, acc_valid, acc_ready, prec_err;
    logic [63:0]      prod_data, acc_data;
    logic [3:0]       select_precision;
    logic [LEN_W-1:0] acc_len;
    logic [7:0]       acc_overflow;

    int tests = 0;
    int fails = 0;

    logic [63:0]       exp_data;
    logic [7:0]        exp_ovf;
    int                m_w;
    logic signed [65:0] m_v[8];
    bit                m_o[8];
    logic [63:0]       dir_q[$];

    sacc_lane_accumulator #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .sclr(sclr),
        .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready),
        .select_precision(select_precision), .acc_len(acc_len),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
        .acc_overflow(acc_overflow), .prec_err(prec_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input logic [3:0] sp);
        case (sp)
            4'b0001: return 8;
            4'b0010: return 16;
            4'b0100: return 32;
            default: return 64;
        endcase
    endfunction

    // reference: each lane is an integer; out-of-range sums are flagged then clamped or wrapped
    task automatic model_add(input logic [63:0] p, input bit first);
        logic signed [65:0] v, t, one, mx, mn;
        logic [63:0] sh, tmp;
        one = 1;
        mx  = (one <<< (m_w - 1)) - one;
        mn  = -(one <<< (m_w - 1));
        for (int l = 0; l < 64 / m_w; l++) begin
            sh = p >> (l * m_w);
            v  = $signed({2'b00, sh});
            v  = v <<< (66 - m_w);
            v  = v >>> (66 - m_w);
            if (first) begin
                m_v[l] = v;
                m_o[l] = 1'b0;
            end else begin
                t = m_v[l] + v;
                if (t > mx || t < mn) begin
                    m_o[l] = 1'b1;
                    if (SAT) t = (t > mx) ? mx : mn;
                    else begin
                        t = t <<< (66 - m_w);
                        t = t >>> (66 - m_w);
                    end
                end
                m_v[l] = t;
            end
        end
        exp_data = '0;
        exp_ovf  = '0;
        for (int l = 0; l < 64 / m_w; l++) begin
            tmp = 64'(m_v[l]);
            if (m_w < 64) tmp = tmp & ((64'd1 << m_w) - 64'd1);
            exp_data = exp_data | (tmp << (l * m_w));
            if (m_o[l])
                for (int k = 0; k < m_w / 8; k++) exp_ovf[l * (m_w / 8) + k] = 1'b1;
        end
    endtask

    // sends one full result; the first product carries acc_ready=1 so it can also close a HOLD
    task automatic feed(input logic [3:0] sp, input int lenv, input bit bubbles);
        int n;
        n   = (lenv == 0) ? (1 << LEN_W) : lenv;
        m_w = width_of(sp);
        for (int i = 0; i < n; i++) begin
            if (bubbles && i > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    prod_valid       = 1'b0;
                    acc_ready        = 1'b0;
                    select_precision = 4'($urandom);
                    acc_len          = LEN_W'($urandom);
                end
            end
            @(negedge clk);
            prod_valid = 1'b1;
            prod_data  = (dir_q.size() > 0) ? dir_q.pop_front() : {$urandom, $urandom};
            acc_ready  = (i == 0);
            if (i == 0) begin
                select_precision = sp;
                acc_len          = LEN_W'(lenv);
            end else begin
                select_precision = 4'($urandom);
                acc_len          = LEN_W'($urandom);
            end
            model_add(prod_data, i == 0);
            @(posedge clk);
            #1;
            if (i < n - 1) check("valid_mid_result", {63'd0, acc_valid}, 64'd0);
        end
        check("valid_after_last", {63'd0, acc_valid}, 64'd1);
        check("acc_data", acc_data, exp_data);
        check("acc_overflow", {56'd0, acc_overflow}, {56'd0, exp_ovf});
    endtask

    task automatic stall(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            prod_valid       = 1'b1;
            prod_data        = {$urandom, $urandom};
            acc_ready        = 1'b0;
            select_precision = 4'($urandom);
            acc_len          = LEN_W'($urandom);
            @(posedge clk);
            #1;
            check("stall_valid", {63'd0, acc_valid}, 64'd1);
            check("stall_prod_ready", {63'd0, prod_ready}, 64'd0);
            check("stall_data", acc_data, exp_data);
            check("stall_ovf", {56'd0, acc_overflow}, {56'd0, exp_ovf});
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        prod_valid = 1'b0;
        acc_ready  = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", {63'd0, acc_valid}, 64'd0);
        check("release_prod_ready", {63'd0, prod_ready}, 64'd1);
        @(negedge clk);
        acc_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sclr = 1'b0; prod_valid = 1'b0; prod_data = '0; acc_ready = 1'b0;
        select_precision = 4'b0001; acc_len = 8'd1;
        #12;
        check("rst_valid", {63'd0, acc_valid}, 64'd0);
        check("rst_data", acc_data, 64'd0);
        check("rst_ovf", {56'd0, acc_overflow}, 64'd0);
        check("rst_prec_err", {63'd0, prec_err}, 64'd0);
        check("rst_prod_ready", {63'd0, prod_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;

        dir_q = '{64'h02, 64'h03, 64'hFF};
        feed(4'b0001, 3, 1'b0);
        check("int8_sum_lane0", {56'd0, acc_data[7:0]}, 64'h04);
        check("int8_sum_ovf", {56'd0, acc_overflow}, 64'h00);
        release_result();

        dir_q = '{64'h70, 64'h70};
        feed(4'b0001, 2, 1'b0);
        check("int8_ovf_lane0", {56'd0, acc_data[7:0]}, SAT ? 64'h7F : 64'hE0);
        check("int8_ovf_flag", {63'd0, acc_overflow[0]}, 64'd1);
        release_result();

        dir_q = '{64'h8000_0001, 64'hFFFF_0002};
        feed(4'b0010, 2, 1'b0);
        check("int16_lane1", {48'd0, acc_data[31:16]}, SAT ? 64'h8000 : 64'h7FFF);
        check("int16_lane0", {48'd0, acc_data[15:0]}, 64'h0003);
        check("int16_ovf", {56'd0, acc_overflow}, 64'h0C);
        release_result();

        for (int r = 0; r < 14; r++) begin
            case ($urandom_range(0, 3))
                0: feed(4'b0001, $urandom_range(1, 6), 1'b1);
                1: feed(4'b0010, $urandom_range(1, 6), 1'b1);
                2: feed(4'b0100, $urandom_range(1, 6), 1'b1);
                default: feed(4'b1000, $urandom_range(1, 6), 1'b1);
            endcase
            stall($urandom_range(0, 3));
        end
        release_result();

        feed(4'b0010, 3, 1'b1);
        stall(5);
        feed(4'b0100, 2, 1'b1);
        release_result();

        feed(4'b0001, 0, 1'b0);
        release_result();

        feed(4'b0011, 1, 1'b0);
        check("prec_err_set", {63'd0, prec_err}, 64'd1);
        release_result();
        feed(4'b0001, 2, 1'b0);
        check("prec_err_sticky", {63'd0, prec_err}, 64'd1);
        @(negedge clk);
        prod_valid = 1'b1;
        prod_data  = 64'h1234;
        acc_ready  = 1'b1;
        sclr       = 1'b1;
        @(posedge clk);
        #1;
        check("sclr_prec_err", {63'd0, prec_err}, 64'd0);
        check("sclr_valid", {63'd0, acc_valid}, 64'd0);
        check("sclr_data", acc_data, 64'd0);
        @(negedge clk);
        sclr = 1'b0; prod_valid = 1'b0; acc_ready = 1'b0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            prod_valid = 1'b1;
            prod_data  = {$urandom, $urandom};
            select_precision = 4'b0001;
            acc_len    = 8'd4;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {63'd0, acc_valid}, 64'd0);
        check("async_rst_data", acc_data, 64'd0);
        check("async_rst_prod_ready", {63'd0, prod_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0; prod_valid = 1'b0;
        feed(4'b0001, 4, 1'b1);
        release_result();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sacc_lane_accumulator.md
SACC_LANE_ACCUMULATOR -- requirements
Module: sacc_lane_accumulator

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of acc_len.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port sclr  input  1  synchronous clear, active-high.
REQ-005 SHALL have port prod_valid  input  1  product word from the multiplier stage is valid this cycle.
REQ-006 SHALL have port prod_data  input  64  packed signed product lanes from the multiplier stage.
REQ-007 SHALL have port prod_ready  output  1  accumulator accepts prod_data this cycle; upstream uses it to gate its ce.
REQ-008 SHALL have port select_precision  input  4  one-hot lane format: 0001 = 8x INT8, 0010 = 4x INT16, 0100 = 2x INT32, 1000 = 1x INT64.
REQ-009 SHALL have port acc_len  input  LEN_W  number of products per result; 0 means 2^LEN_W.
REQ-010 SHALL have port acc_valid  output  1  result available.
REQ-011 SHALL have port acc_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port acc_data  output  64  packed accumulated lanes, same format as the products.
REQ-013 SHALL have port acc_overflow  output  8  per-byte overflow flags for the current result.
REQ-014 SHALL have port prec_err  output  1  sticky flag: a non-one-hot select_precision was latched.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-016 SHALL drive prod_ready = 1 in IDLE and ACCUM, and prod_ready = acc_ready in HOLD.
REQ-017 A product SHALL be accepted only when prod_valid and prod_ready are both 1.
REQ-018 IDLE: on an accepted product, SHALL latch select_precision and acc_len, load the lanes, set count to 1, then go to HOLD if the length is 1, else to ACCUM.
REQ-019 ACCUM: each accepted product SHALL be added lane-wise, and count SHALL increment; when count reaches the latched length, the FSM SHALL go to HOLD.
REQ-020 Cycles in ACCUM without prod_valid SHALL leave all state unchanged (bubbles allowed).
REQ-021 HOLD: acc_valid SHALL be 1, and acc_data and acc_overflow SHALL be stable until acc_valid and acc_ready are both 1.
REQ-022 On a HOLD handshake without an accepted product, the FSM SHALL go to IDLE.
REQ-023 On a HOLD handshake with a simultaneous accepted product, that product SHALL start a new result exactly as in REQ-018, with no lost cycle.
REQ-024 Latency SHALL be: acc_valid rises 1 cycle after the final product is accepted.
REQ-025 Lanes SHALL be signed two's complement, each lane its own width, with no carry across lane boundaries.
REQ-026 Changes to select_precision or acc_len during ACCUM or HOLD SHALL be ignored until the next REQ-018 latch.
REQ-027 A latched non-one-hot select_precision SHALL be treated as INT64 and SHALL set prec_err.
REQ-028 prec_err SHALL clear only on rst or sclr.
REQ-029 A lane overflow SHALL set every acc_overflow bit covering that lane (INT16 lane k sets bits 2k and 2k+1).
REQ-030 acc_overflow SHALL be sticky within a result and SHALL clear when a new result starts.

Reset
REQ-031 rst SHALL asynchronously force state IDLE, count 0, and outputs acc_valid 0, acc_data 0, acc_overflow 0, prec_err 0; prod_ready SHALL be 1 after reset.
REQ-032 sclr SHALL produce the same state as rst on the next edge, with priority over every other input except rst.
REQ-033 A result in progress when rst or sclr is asserted SHALL be discarded.

Configuration
REQ-034 Macro ACC_SATURATE_EN defined: an overflowing lane SHALL clamp to the lane signed max or min, and later additions SHALL continue from the clamped value.
REQ-035 Macro ACC_SATURATE_EN undefined: lanes SHALL wrap modulo 2^lane_width; overflow flags SHALL still be reported.

Verification
REQ-036 INT8, acc_len=3, lane0 products 0x02, 0x03, 0xFF -> acc_data[7:0]=0x04, acc_valid 1 cycle after the third product, acc_overflow=0.
REQ-037 INT8, acc_len=2, lane0 products 0x70, 0x70 -> with ACC_SATURATE_EN acc_data[7:0]=0x7F; without it 0xE0; acc_overflow[0]=1 in both cases.
REQ-038 INT16, acc_len=2, lane1 products 0x8000, 0xFFFF -> acc_data[31:16]=0x8000 with ACC_SATURATE_EN, acc_overflow=0x0C, lane0 unaffected.
REQ-039 HOLD with acc_ready=0 for 5 cycles, then acc_ready=1 together with prod_valid -> acc_data stable for 5 cycles, prod_ready=0 while stalled, new result started with count=1.
REQ-040 select_precision=0011 latched, acc_len=1 -> INT64 sum produced and prec_err=1 until sclr.
REQ-041 rst asserted mid-ACCUM (count=2 of 4) -> acc_valid 0 and acc_data 0 immediately; the next 4 products yield only their own sum.
